// File: rtl/mul_pipe.sv
// mul_pipe -- two-stage pipelined 32x32 multiplier for mul.w / mulh.w / mulh.wu.
//
// Stage 1 (end of EX) registers four partial products of the 33-bit
// extended operands. Stage 2 (MEM) sums them combinationally and selects
// the low or high result word.
//
// Ports:
//   clk        in   pipeline clock
//   rst        in   synchronous active-high reset
//   start      in   EX holds a valid multiply this cycle
//   op[1:0]    in   00 mul.w, 01 mulh.w, 10 mulh.wu, 11 behaves as 00
//   src1, src2 in   rj / rk operands, sampled with start
//   stall      in   pipeline stall; holds all stage-1 state
//   flush      in   kills the stage-1 entry (beats stall and start)
//   mul_valid  out  stage-2 result belongs to a live instruction
//   MUL_res    out  product word, zero whenever mul_valid is low
module mul_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             stall,
  input  logic             flush,
  output logic             mul_valid,
  output logic [WIDTH-1:0] MUL_res
);

  if (WIDTH != 32) begin : g_bad_width
    $error("mul_pipe: only WIDTH=32 is supported");
  end

  localparam logic [1:0] OP_MULH_W  = 2'b01;
  localparam logic [1:0] OP_MULH_WU = 2'b10;

  // ---------------------------------------------------------------------------
  // Stage 1: operand extension and partial products
  // ---------------------------------------------------------------------------
  logic        [32:0] a_ext, b_ext;
  logic signed [16:0] al_s, ah_s, bl_s, bh_s;

  logic        [31:0] ll_d, ll_q;
  logic signed [33:0] lh_d, lh_q;
  logic signed [33:0] hl_d, hl_q;
  // Only the low 32 bits of hh reach P[63:0] (hh is weighted by 2^32), so
  // the two upper bits of the 34-bit product are not stored.
  logic        [31:0] hh_d, hh_q;
  logic        [1:0]  op_d, op_q;
  logic               valid_d, valid_q;
  logic               load;

  // NOTE: every signal written in this always_comb gets a value on every path
  // (defaults / full if-else), so no latch is inferred.
  always_comb begin
    // Signed extension only for mulh.w; the low word is identical either way.
    a_ext = {(op == OP_MULH_W) & src1[31], src1};
    b_ext = {(op == OP_MULH_W) & src2[31], src2};

    // Low halves are unsigned 16-bit: a zero top bit makes them non-negative
    // as 17-bit signed values so all mixed products use signed arithmetic.
    al_s = {1'b0, a_ext[15:0]};
    bl_s = {1'b0, b_ext[15:0]};
    ah_s = a_ext[32:16];
    bh_s = b_ext[32:16];

    // Flush beats stall, stall beats start.
    load    = start & ~stall & ~flush;
    valid_d = flush ? 1'b0 : (stall ? valid_q : start);

    ll_d = ll_q;
    lh_d = lh_q;
    hl_d = hl_q;
    hh_d = hh_q;
    op_d = op_q;
    if (load) begin
      ll_d = 32'(a_ext[15:0]) * 32'(b_ext[15:0]);
      lh_d = 34'(al_s) * 34'(bh_s);
      hl_d = 34'(ah_s) * 34'(bl_s);
      hh_d = 32'(34'(ah_s) * 34'(bh_s));
      op_d = op;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge _d value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      ll_q    <= '0;
      lh_q    <= '0;
      hl_q    <= '0;
      hh_q    <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      ll_q    <= ll_d;
      lh_q    <= lh_d;
      hl_q    <= hl_d;
      hh_q    <= hh_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sum partial products and select result word
  // ---------------------------------------------------------------------------
  // Bits above 63 of the full product are never selected, so the sum is
  // evaluated modulo 2^64; this is exact for the bits that are used.
  logic [63:0] mid_sum;
  logic [63:0] prod;
  logic        sel_high;

  always_comb begin
    mid_sum  = {{30{lh_q[33]}}, lh_q} + {{30{hl_q[33]}}, hl_q};
    prod     = {hh_q, 32'b0} + (mid_sum << 16) + {32'b0, ll_q};
    sel_high = (op_q == OP_MULH_W) || (op_q == OP_MULH_WU);

    mul_valid = valid_q;
    MUL_res   = '0;
    if (valid_q) begin
      MUL_res = sel_high ? prod[63:32] : prod[31:0];
    end
  end

endmodule
